freq_div_odd: RTL and testbench



---
 rtl/freq_div_odd.sv | 59 +++++
 tb/tb_freq_div_odd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/freq_div_odd.sv
// Clock divider by DIV with exactly 50% duty for both odd and even ratios.
// Odd ratios AND a rising-edge phase flop with a falling-edge copy of itself.
module freq_div_odd #(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    output logic out
);
    localparam int CW = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
    localparam int H  = (DIV + 1) / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(H);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          p_reg;
    logic          p_next;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("freq_div_odd: DIV must be >= 2");
        end
    endgenerate

    always_comb begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        p_next   = (cnt_reg < CNT_HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            p_reg   <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            p_reg   <= p_next;
        end
    end

    generate
        if (DIV % 2 == 1) begin : g_odd
            // Half-cycle delayed copy trims the extra half period off p's high time.
            logic n_reg;

            always_ff @(negedge clk or negedge rst) begin
                if (!rst) begin
                    n_reg <= 1'b0;
                end else begin
                    n_reg <= p_reg;
                end
            end

            assign out = p_reg & n_reg;
        end else begin : g_even
            assign out = p_reg;
        end
    endgenerate
endmodule

// File: tb/tb_freq_div_odd.sv
// Directed bench for freq_div_odd: five ratios share one clock and reset,
// every output edge is timestamped and compared against the expected waveform.
module tb_freq_div_odd;
    localparam int NDUT = 5;

    function automatic int div_of(input int i);
        case (i)
            0:       return 3;
            1:       return 5;
            2:       return 7;
            3:       return 2;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        int     idx;
        longint t;
        logic   val;
    } evt_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NDUT-1:0] outs;
    evt_t            event_q[$];
    int              checks = 0;
    int              errors = 0;
    longint          edge1;
    longint          t_end;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            freq_div_odd #(.DIV(div_of(gi))) u_dut (
                .clk (clk),
                .rst (rst),
                .out (outs[gi])
            );

            always @(outs[gi]) event_q.push_back('{gi, longint'($time), outs[gi]});
        end
    endgenerate

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Clears the edge log, releases reset and records the first rising edge after release.
    task automatic release_now();
        event_q.delete();
        rst = 1'b1;
        @(posedge clk);
        edge1 = $time;
    endtask

    // Odd ratios rise half a cycle after edge 1, even ratios at edge 1;
    // after that every edge is DIV*T/2 apart and levels alternate.
    task automatic run_and_check(input string tag, input int run_len);
        #(run_len);
        t_end = $time;
        for (int i = 0; i < NDUT; i++) begin
            int     div;
            int     k;
            int     n_exp;
            longint first;
            div   = div_of(i);
            k     = 0;
            n_exp = 0;
            first = edge1 + ((div % 2 == 1) ? 5 : 0);
            while (first + longint'(n_exp) * div * 5 < t_end) n_exp++;
            foreach (event_q[j]) begin
                if (event_q[j].idx == i) begin
                    longint exp_t;
                    logic   exp_v;
                    exp_t = first + longint'(k) * div * 5;
                    exp_v = (k % 2 == 0);
                    checks++;
                    if (event_q[j].t !== exp_t || event_q[j].val !== exp_v) begin
                        errors++;
                        $display("FAIL %s div%0d edge%0d: got t=%0d out=%b, required t=%0d out=%b",
                                 tag, div, k, event_q[j].t - edge1, event_q[j].val,
                                 exp_t - edge1, exp_v);
                    end
                    k++;
                end
            end
            checks++;
            if (k != n_exp) begin
                errors++;
                $display("FAIL %s div%0d edge_count: got %0d, required %0d", tag, div, k, n_exp);
            end
            $display("%s div%0d: %0d edges checked", tag, div, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                checks++;
                if (outs[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_out div%0d: got %b, required 0", div_of(i), outs[i]);
                end
            end
            checks++;
            if (g_dut[0].u_dut.cnt_reg !== 2'd0) begin
                errors++;
                $display("FAIL reset_cnt div3: got %0d, required 0", g_dut[0].u_dut.cnt_reg);
            end
            checks++;
            if (g_dut[3].u_dut.cnt_reg !== 1'd0) begin
                errors++;
                $display("FAIL reset_cnt div2: got %0d, required 0", g_dut[3].u_dut.cnt_reg);
            end
            $display("reset hold: outs=%b at t=%0t", outs, $time);
        end
    endtask

    task automatic test_first_release();
        release_now();
        run_and_check("first_release", 612);
    endtask

    task automatic test_midrun_reset();
        int waited;
        waited = 0;
        @(negedge clk);
        #1;
        while (outs[0] !== 1'b1 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (outs[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_wait div3: got out=%b, required 1 within 100 cycles", outs[0]);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (outs[i] !== 1'b0) begin
                errors++;
                $display("FAIL midrun_async div%0d: got %b, required 0", div_of(i), outs[i]);
            end
        end
        checks++;
        if (g_dut[0].u_dut.cnt_reg !== 2'd0) begin
            errors++;
            $display("FAIL midrun_cnt div3: got %0d, required 0", g_dut[0].u_dut.cnt_reg);
        end
        $display("midrun reset asserted at t=%0t outs=%b", $time, outs);
        #9;
        release_now();
        run_and_check("midrun_release", 612);
    endtask

    task automatic test_release_near_fall();
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL near_fall_hold: got %b, required 00000", outs);
        end
        #8;
        release_now();
        run_and_check("near_fall_release", 432);
    endtask

    initial begin
        test_reset();
        test_first_release();
        test_midrun_reset();
        test_release_near_fall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
